// File: rtl/io_input.sv
// Memory-mapped input ports for the MEM-stage I/O space: synchronize, debounce,
// flag changes (write-1-to-clear) and count port0 change events.
`timescale 1ns/1ps
module io_input #(
   parameter int PORT_WIDTH      = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  io_clk,
   input  logic                  reset,
   input  logic [31:0]           addr,
   input  logic [31:0]           datain,
   input  logic                  write_io_enable,
   input  logic [PORT_WIDTH-1:0] in_port0,
   input  logic [PORT_WIDTH-1:0] in_port1,
   output logic [31:0]           io_read_data,
   output logic                  irq_pending
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [4:0] REG_IN0    = 5'd0;
   localparam logic [4:0] REG_IN1    = 5'd1;
   localparam logic [4:0] REG_STATUS = 5'd2;
   localparam logic [4:0] REG_EVCNT  = 5'd3;

   logic [PORT_WIDTH-1:0] raw_s [2];
   logic [PORT_WIDTH-1:0] deb_s [2];
   logic                  changed_s [2];
   logic [1:0]            chg_r;
   logic [31:0]           evcnt_r;
   logic [4:0]            reg_sel_s;
   logic                  wr_status_s;
   logic                  wr_evcnt_s;
   logic [31:0]           rd_mux_s;
   logic                  unused_s;

   function automatic logic [31:0] zext(input logic [PORT_WIDTH-1:0] v);
      logic [31:0] r;
      r = 32'd0;
      r[PORT_WIDTH-1:0] = v;
      return r;
   endfunction

   assign raw_s[0]    = in_port0;
   assign raw_s[1]    = in_port1;
   assign reg_sel_s   = addr[6:2];
   assign wr_status_s = write_io_enable && (reg_sel_s == REG_STATUS);
   assign wr_evcnt_s  = write_io_enable && (reg_sel_s == REG_EVCNT);
   assign unused_s    = ^{addr[31:7], addr[1:0], datain[31:2]};

   for (genvar g = 0; g < 2; g++) begin : g_port
      logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync_r;
      logic [PORT_WIDTH-1:0]                  deb_r;
      logic [CNT_W-1:0]                       cnt_r;
      logic [PORT_WIDTH-1:0]                  sync_s;

      assign sync_s       = sync_r[SYNC_STAGES-1];
      assign deb_s[g]     = deb_r;
      assign changed_s[g] = (sync_s != deb_r) && (cnt_r == CNT_LAST);

      // Synchronizer chain and word-level debounce; stability is judged against
      // the accepted value, so bit wiggles that still differ keep counting.
      always_ff @(posedge io_clk or posedge reset) begin
         if (reset) begin
            sync_r <= '0;
            deb_r  <= '0;
            cnt_r  <= '0;
         end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[g]};
            if (sync_s == deb_r) begin
               cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
               deb_r <= sync_s;
               cnt_r <= '0;
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end
      end
   end

   // Change flags (set beats W1C) and port0 event counter (clear beats increment).
   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         chg_r   <= 2'b00;
         evcnt_r <= 32'd0;
      end else begin
         chg_r[0] <= changed_s[0] | (chg_r[0] & ~(wr_status_s & datain[0]));
         chg_r[1] <= changed_s[1] | (chg_r[1] & ~(wr_status_s & datain[1]));
         if (wr_evcnt_s) begin
            evcnt_r <= 32'd0;
         end else if (changed_s[0]) begin
            evcnt_r <= evcnt_r + 32'd1;
         end
      end
   end

   // Register read mux.
   always_comb begin
      rd_mux_s = 32'd0;
      case (reg_sel_s)
         REG_IN0:    rd_mux_s = zext(deb_s[0]);
         REG_IN1:    rd_mux_s = zext(deb_s[1]);
         REG_STATUS: rd_mux_s = {30'd0, chg_r};
         REG_EVCNT:  rd_mux_s = evcnt_r;
         default:    rd_mux_s = 32'd0;
      endcase
   end

   // Read data is registered every cycle so it lines up with data-memory output.
   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         io_read_data <= 32'd0;
      end else begin
         io_read_data <= rd_mux_s;
      end
   end

   assign irq_pending = chg_r[0] | chg_r[1];

endmodule
